// File: rtl/axi_read_master.sv
// AXI4 read-channel initiator: one INCR burst per command, beats forwarded with
// backpressure and checked for response, ID and last-beat consistency.
module axi_read_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MASTER_ID  = 0
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  done,
  output logic                  busy,
  output logic [2:0]            err_status,
  output logic [ID_WIDTH-1:0]   M_AXI_arid,
  output logic [ADDR_WIDTH-1:0] M_AXI_araddr,
  output logic [7:0]            M_AXI_arlen,
  output logic [2:0]            M_AXI_arsize,
  output logic [1:0]            M_AXI_arburst,
  output logic [1:0]            M_AXI_arlock,
  output logic [3:0]            M_AXI_arcache,
  output logic [2:0]            M_AXI_arprot,
  output logic [3:0]            M_AXI_arqos,
  output logic [3:0]            M_AXI_arregion,
  output logic                  M_AXI_arvalid,
  input  logic                  M_AXI_arready,
  input  logic [ID_WIDTH-1:0]   M_AXI_rid,
  input  logic [DATA_WIDTH-1:0] M_AXI_rdata,
  input  logic [1:0]            M_AXI_rresp,
  input  logic                  M_AXI_rlast,
  input  logic                  M_AXI_rvalid,
  output logic                  M_AXI_rready
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // ADDR  | AR request presented, waiting for arready
  // DATA  | collecting R beats until rlast or the beat count reaches arlen
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam int unsigned           SIZE      = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'((64'd1 << SIZE) - 64'd1);
  localparam logic [ID_WIDTH-1:0]   ID_VAL    = ID_WIDTH'(MASTER_ID);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic [7:0]            count_q;
  logic [ID_WIDTH-1:0]   arid_q;
  logic [2:0]            arsize_q;
  logic [1:0]            arburst_q;
  logic                  arvalid_q;
  logic [2:0]            err_q;
  logic                  done_q;

  logic cmd_fire, ar_fire, r_fire, at_len, burst_end;

  assign at_len    = (count_q == arlen_q);
  assign burst_end = M_AXI_rlast || at_len;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign ar_fire   = arvalid_q && M_AXI_arready;
  assign r_fire    = M_AXI_rvalid && M_AXI_rready;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cmd_ready    = 1'b0;
    M_AXI_rready = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = ADDR;
      end
      ADDR: begin
        if (ar_fire) state_d = DATA;
      end
      DATA: begin
        M_AXI_rready = out_ready;
        out_valid    = M_AXI_rvalid;
        out_last     = burst_end;
        if (r_fire && burst_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      araddr_q  <= '0;
      arlen_q   <= '0;
      count_q   <= '0;
      arid_q    <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      arvalid_q <= 1'b0;
      err_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cmd_fire) begin
        araddr_q  <= cmd_addr & ~ADDR_MASK;
        arlen_q   <= cmd_len;
        arid_q    <= ID_VAL;
        arsize_q  <= 3'(SIZE);
        arburst_q <= 2'b01;
        arvalid_q <= 1'b1;
        err_q     <= '0;
        count_q   <= '0;
      end
      if (ar_fire) arvalid_q <= 1'b0;
      if (r_fire) begin
        count_q <= count_q + 8'd1;
        if (M_AXI_rresp != 2'b00) err_q[0] <= 1'b1;
        if (M_AXI_rid != ID_VAL)  err_q[2] <= 1'b1;
        // rlast and the local count must agree on which beat ends the burst
        if (burst_end && (M_AXI_rlast != at_len)) err_q[1] <= 1'b1;
        if (burst_end) done_q <= 1'b1;
      end
    end
  end

  assign out_data       = M_AXI_rdata;
  assign done           = done_q;
  assign busy           = (state_q != IDLE);
  assign err_status     = err_q;
  assign M_AXI_arid     = arid_q;
  assign M_AXI_araddr   = araddr_q;
  assign M_AXI_arlen    = arlen_q;
  assign M_AXI_arsize   = arsize_q;
  assign M_AXI_arburst  = arburst_q;
  assign M_AXI_arlock   = 2'b00;
  assign M_AXI_arcache  = 4'h0;
  assign M_AXI_arprot   = 3'h0;
  assign M_AXI_arqos    = 4'h0;
  assign M_AXI_arregion = 4'h0;
  assign M_AXI_arvalid  = arvalid_q;

endmodule
